// File: rtl/sz_stream_predictor_if.sv
// Sample-in / result-out bundle for the SZ prediction stage.
// master drives samples and result backpressure; slave is the predictor.
interface sz_stream_predictor_if #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic [1:0]               in_mode;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [CODE_W-1:0]        out_code;
  logic [1:0]               out_sel;
  logic signed [DATA_W-1:0] out_recon;
  logic signed [DATA_W-1:0] out_err;
  logic                     out_last;

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_code, out_sel, out_recon, out_err, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_code, out_sel, out_recon, out_err, out_last
  );
endinterface

// File: rtl/sz_stream_predictor.sv
// SZ predictor/quantizer: neighbor/linear/quadratic prediction from reconstructed history.
// Latency 1 cycle; a stalled result blocks input and freezes history.
module sz_stream_predictor #(
  parameter int DATA_W   = 32,
  parameter int CODE_W   = 8,
  parameter int EB_SHIFT = 2
) (
  input logic                clk,
  input logic                rst,
  sz_stream_predictor_if.slave io
);
  localparam int PW = DATA_W + 3;
  localparam int QW = DATA_W + 4;
  localparam int BS = EB_SHIFT + 1;
  localparam logic signed [QW-1:0] L_EB   = QW'(1 << EB_SHIFT);
  localparam logic signed [QW-1:0] L_QMAX = QW'((1 << (CODE_W - 1)) - 1);
  localparam logic signed [QW-1:0] L_QMIN = -L_QMAX;
  localparam logic [CODE_W-1:0]    L_CODE_OFS = CODE_W'(1 << (CODE_W - 1));

  logic signed [DATA_W-1:0] r_h1, r_h2, r_h3;
  logic [1:0]               r_idx;
  logic                     r_out_valid;
  logic [CODE_W-1:0]        r_out_code;
  logic [1:0]               r_out_sel;
  logic signed [DATA_W-1:0] r_out_recon;
  logic signed [DATA_W-1:0] r_out_err;
  logic                     r_out_last;

  logic                     w_acc;
  logic signed [PW-1:0]     w_h1p, w_h2p, w_h3p;
  logic signed [PW-1:0]     w_p0, w_p1, w_p2;
  logic signed [QW-1:0]     w_x, w_p0q, w_p1q, w_p2q;
  logic signed [QW-1:0]     w_e0, w_e1, w_e2;
  logic signed [QW-1:0]     w_a0, w_a1, w_a2, w_best;
  logic [1:0]               w_kmax, w_k;
  logic signed [QW-1:0]     w_p_sel, w_e_sel, w_sum, w_q, w_recon_w;
  logic                     w_q_ok, w_r_ok, w_pred;
  logic signed [DATA_W-1:0] w_recon, w_err;
  logic [CODE_W-1:0]        w_code;
  logic [1:0]               w_sel;

  assign io.in_ready = !rst && (!r_out_valid || io.out_ready);
  assign w_acc       = io.in_valid && io.in_ready;

  assign w_h1p = {{3{r_h1[DATA_W-1]}}, r_h1};
  assign w_h2p = {{3{r_h2[DATA_W-1]}}, r_h2};
  assign w_h3p = {{3{r_h3[DATA_W-1]}}, r_h3};
  assign w_p0  = w_h1p;
  assign w_p1  = (w_h1p <<< 1) - w_h2p;
  assign w_p2  = (w_h1p <<< 1) + w_h1p - (w_h2p <<< 1) - w_h2p + w_h3p;

  assign w_x   = {{4{io.in_data[DATA_W-1]}}, io.in_data};
  assign w_p0q = {w_p0[PW-1], w_p0};
  assign w_p1q = {w_p1[PW-1], w_p1};
  assign w_p2q = {w_p2[PW-1], w_p2};
  assign w_e0  = w_x - w_p0q;
  assign w_e1  = w_x - w_p1q;
  assign w_e2  = w_x - w_p2q;
  assign w_a0  = w_e0[QW-1] ? -w_e0 : w_e0;
  assign w_a1  = w_e1[QW-1] ? -w_e1 : w_e1;
  assign w_a2  = w_e2[QW-1] ? -w_e2 : w_e2;

  // Highest usable predictor index; meaningless at idx 0, which is forced unpredictable.
  assign w_kmax = (r_idx == 2'd3) ? 2'd2 : r_idx - 2'd1;

  always_comb begin
    w_k    = 2'd0;
    w_best = w_a0;
    if (io.in_mode != 2'd3) begin
      w_k = (io.in_mode > w_kmax) ? w_kmax : io.in_mode;
    end else begin
      if (w_kmax >= 2'd1 && w_a1 < w_best) begin
        w_k    = 2'd1;
        w_best = w_a1;
      end
      if (w_kmax == 2'd2 && w_a2 < w_best) begin
        w_k = 2'd2;
      end
    end
  end

  always_comb begin
    w_p_sel = w_p0q;
    w_e_sel = w_e0;
    case (w_k)
      2'd1: begin
        w_p_sel = w_p1q;
        w_e_sel = w_e1;
      end
      2'd2: begin
        w_p_sel = w_p2q;
        w_e_sel = w_e2;
      end
      default: ;
    endcase
  end

  assign w_sum     = w_e_sel + L_EB;
  assign w_q       = w_sum >>> BS;
  assign w_recon_w = w_p_sel + (w_q <<< BS);
  assign w_q_ok    = (w_q <= L_QMAX) && (w_q >= L_QMIN);
  assign w_r_ok    = (w_recon_w[QW-1:DATA_W-1] == {(QW-DATA_W+1){w_recon_w[DATA_W-1]}});
  assign w_pred    = (r_idx != 2'd0) && w_q_ok && w_r_ok;

  assign w_recon = w_pred ? w_recon_w[DATA_W-1:0] : io.in_data;
  assign w_code  = w_pred ? (w_q[CODE_W-1:0] + L_CODE_OFS) : '0;
  assign w_sel   = w_pred ? w_k : 2'd3;
  assign w_err   = io.in_data - w_recon;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h1        <= '0;
      r_h2        <= '0;
      r_h3        <= '0;
      r_idx       <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_code  <= '0;
      r_out_sel   <= 2'd3;
      r_out_recon <= '0;
      r_out_err   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_code  <= w_code;
      r_out_sel   <= w_sel;
      r_out_recon <= w_recon;
      r_out_err   <= w_err;
      r_out_last  <= io.in_last;
      if (io.in_last) begin
        r_h1  <= '0;
        r_h2  <= '0;
        r_h3  <= '0;
        r_idx <= 2'd0;
      end else begin
        r_h1  <= w_recon;
        r_h2  <= r_h1;
        r_h3  <= r_h2;
        r_idx <= (r_idx == 2'd3) ? 2'd3 : r_idx + 2'd1;
      end
    end else if (io.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io.out_valid = r_out_valid;
  assign io.out_code  = r_out_code;
  assign io.out_sel   = r_out_sel;
  assign io.out_recon = r_out_recon;
  assign io.out_err   = r_out_err;
  assign io.out_last  = r_out_last;
endmodule

// File: doc/sz_stream_predictor.md
# sz_stream_predictor

Streaming SZ prediction + quantization stage for signed fixed-point samples. It keeps its own history of reconstructed values, so callers supply only the new sample. It evaluates neighbor, linear and quadratic curve-fit predictors and quantizes the prediction error against a power-of-two error bound. Per sample it emits a quantization code, the reconstructed value and the real error. It sits between the sample source and the Huffman/packing stages.

## Interface
- DATA_W, 32, sample width (signed two's complement)
- CODE_W, 8, quantization code width; 2^CODE_W bins, code 0 = unpredictable
- EB_SHIFT, 2, error bound eb = 2^EB_SHIFT; bin width 2^(EB_SHIFT+1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  stage accepts sample this cycle
- in_data  in  DATA_W  signed sample x
- in_mode  in  2  0 = neighbor, 1 = linear, 2 = quadratic, 3 = best-fit; sampled with in_data
- in_last  in  1  last sample of block; history cleared after it
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_code  out  CODE_W  quantization code
- out_sel  out  2  predictor used: 0 neighbor, 1 linear, 2 quadratic, 3 none (unpredictable)
- out_recon  out  DATA_W  reconstructed (decompressed) value
- out_err  out  DATA_W  real error x − recon, signed
- out_last  out  1  copy of in_last

## Operation
- History registers h1, h2, h3 hold the last three *reconstructed* values, never raw inputs. idx is a saturating 0..3 sample counter.
- Predictions are computed signed in DATA_W+3 bits:
  - P0 = h1
  - P1 = 2·h1 − h2
  - P2 = 3·h1 − 3·h2 + h3
- Predictor availability by idx:
  - idx 0: none; the sample is forced unpredictable.
  - idx 1: P0 only.
  - idx 2: P0, P1.
  - idx ≥ 3: all three.
- Predictor choice by in_mode:
  - Modes 0–2 request that predictor. If it is unavailable, use the highest available index below it.
  - Mode 3 picks the minimum |x − Pk| among available predictors. Ties go to the lower k.
- Quantization, in DATA_W+4 bits signed:
  - e = x − P
  - q = (e + eb) >>> (EB_SHIFT+1), arithmetic shift (floor)
  - recon = P + q·2^(EB_SHIFT+1)
  - guarantees |x − recon| ≤ eb
- The sample is predictable iff both hold:
  - |q| ≤ 2^(CODE_W−1) − 1
  - recon fits the signed DATA_W range
- Predictable result: out_code = q + 2^(CODE_W−1), out_sel = k.
- Unpredictable result: out_code = 0, out_sel = 3, recon = x, out_err = 0.
- On acceptance: h3 ← h2, h2 ← h1, h1 ← recon, idx ← min(idx+1, 3).
- If in_last is set on the accepted sample: h1..h3 ← 0 and idx ← 0 instead.

## Timing
- Accept when in_valid && in_ready.
- in_ready = !rst && (!out_valid || out_ready).
- Latency is 1 cycle: a sample accepted at edge k has all out_* valid after edge k. Throughput is 1 sample per cycle.
- Prediction, quantization and reconstruction form a single-cycle loop from the history registers. History and output registers update on the same edge.
- When out_valid && !out_ready: out_* hold stable, in_ready = 0, and history does not change.
- Simultaneous output handshake and new acceptance in one cycle: the output register reloads with no bubble.
- Reset values: out_valid 0, out_code 0, out_sel 3, out_recon 0, out_err 0, out_last 0, h1..h3 0, idx 0.
- Reset mid-stream discards any pending output. The first sample after reset has idx 0.

## Test plan
All scenarios use DATA_W=32, CODE_W=8, EB_SHIFT=2 (eb=4, bin 8).

1. **Reset:** rst high 5 cycles with in_valid=1 → in_ready=0 and out_valid=0. In the cycle after rst falls, in_ready=1.
2. **Linear mode:** mode 1, inputs 100, 110, 120, 130, out_ready=1 → (code, sel, recon, err):
   - (0, 3, 100, 0)
   - (129, 0, 108, 2)
   - (129, 1, 124, −4)
   - (127, 1, 132, −2)
3. **Best-fit tie:** mode 3, inputs 50, 50, 50, 50 → codes 0, 128, 128, 128; sels 3, 0, 0, 0; all recon 50.
4. **Unpredictable:** mode 0, inputs 0, 2000 → second sample gives q = 250 (out of range), so code 0, sel 3, recon 2000, err 0. A following 2000 gives code 128, sel 0.
5. **Backpressure:**
   - Stimulus: hold out_ready=0 for 3 cycles mid-stream.
   - Required: out_* stable and in_ready=0 throughout.
   - Required: the full output sequence equals the unstalled run of scenario 2.
6. **Block boundary:** inputs 100, 110 (in_last=1), 100 → third sample code 0, sel 3, out_last=1 on the second result only.
